// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment driver for a common-anode panel.
// Hex or iterative double-dabble decimal display, blanking, PWM and overflow dashes.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 16,
  parameter int SCAN_DIV    = 16384,
  parameter int BLANK_ZEROS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              dec_mode,
  input  logic [DIGITS-1:0] dp_in,
  input  logic [3:0]        brightness,
  output logic              busy,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int NB  = 4 * DIGITS;
  localparam int SUB = SCAN_DIV / 16;
  localparam int PW  = $clog2(SCAN_DIV);
  localparam int SW  = $clog2(SUB);
  localparam int IW  = $clog2(DIGITS);
  localparam int CW  = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_LIM = pow10(DIGITS);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [NB-1:0]     disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [NB-1:0]     bcd_q, bcd_d;
  logic              povf_q, povf_d;
  logic [PW-1:0]     presc_q;
  logic [SW-1:0]     sub_q;
  logic [3:0]        slot_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [63:0]       val_ext;
  logic              hex_ovf, dec_ovf;
  logic [NB-1:0]     adj, dd_bcd;

  assign val_ext = 64'(value);
  assign hex_ovf = (val_ext >> NB) != 64'd0;
  assign dec_ovf = val_ext >= DEC_LIM;

  // One double-dabble step: add 3 to digits >= 5, then shift in next bit
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    dd_bcd = {adj[NB-2:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    povf_d = povf_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (busy_q) begin
      bin_d = bin_q << 1;
      bcd_d = dd_bcd;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        disp_d = dd_bcd;
        ovf_d  = povf_q;
      end
    end else if (load) begin
      if (dec_mode) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        bin_d  = value;
        bcd_d  = '0;
        povf_d = dec_ovf;
      end else begin
        disp_d = val_ext[NB-1:0];
        ovf_d  = hex_ovf;
      end
    end
  end

  logic [DIGITS-1:0] blank;
  logic              nz;
  logic [3:0]        cur_nib;
  logic              cur_blank, cur_dp, on;

  // Digit k is blank when it and everything above it is zero
  always_comb begin
    nz    = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      nz       = nz | (disp_q[4*k +: 4] != 4'd0);
      blank[k] = (BLANK_ZEROS != 0) && !nz;
    end
  end

  always_comb begin
    cur_nib   = disp_q[3:0];
    cur_blank = 1'b0;
    cur_dp    = dp_in[0];
    for (int k = 1; k < DIGITS; k++) begin
      if (IW'(k) == idx_q) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_blank = blank[k];
        cur_dp    = dp_in[k];
      end
    end
  end

  assign on = (presc_q != '0) && (slot_q < brightness);

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (on) begin
      an_d = ~(DIGITS'(1) << idx_q);
      dp_d = ~cur_dp;
      if (ovf_q)          seg_d = 7'b0111111;
      else if (cur_blank) seg_d = 7'h7F;
      else                seg_d = glyph(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      povf_q  <= 1'b0;
      presc_q <= '0;
      sub_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      povf_q <= povf_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      if (sub_q == SW'(SUB - 1)) begin
        sub_q  <= '0;
        slot_q <= slot_q + 4'd1;
      end else begin
        sub_q <= sub_q + SW'(1);
      end
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: 4-digit and 5-digit instances.
// Expected images are modelled arithmetically and compared over a full scan.
module tb_ssd_scan_driver;

  typedef logic [7:0][6:0] img_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, load5, dec_mode;
  logic [15:0] value;
  logic [3:0]  dp_in, brightness;
  logic        busy4, busy5, dp4, dp5;
  logic [3:0]  an4;
  logic [4:0]  an5;
  logic [6:0]  seg4, seg5;

  img_t exp_q[$];
  img_t shown;
  int   n_chk = 0;
  int   n_err = 0;

  ssd_scan_driver #(.DIGITS(4), .WIDTH(16), .SCAN_DIV(32), .BLANK_ZEROS(1)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .dp_in(dp_in), .brightness(brightness), .busy(busy4), .an(an4),
    .seg(seg4), .dp(dp4)
  );

  ssd_scan_driver #(.DIGITS(5), .WIDTH(16), .SCAN_DIV(32), .BLANK_ZEROS(1)) u_dut5 (
    .clk(clk), .rst(rst), .value(value), .load(load5), .dec_mode(dec_mode),
    .dp_in(5'b00000), .brightness(brightness), .busy(busy5), .an(an5),
    .seg(seg5), .dp(dp5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input longint unsigned n);
    case (n)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic img_t model(input longint unsigned v, input bit dec, input int nd);
    img_t r;
    longint unsigned base, lim, p;
    base = dec ? 10 : 16;
    lim  = 1;
    for (int k = 0; k < nd; k++) lim = lim * base;
    r = '1;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (v >= lim)            r[k] = 7'b0111111;
      else if (k > 0 && v < p) r[k] = 7'b1111111;
      else                     r[k] = glyph((v / p) % base);
      p = p * base;
    end
    return r;
  endfunction

  task automatic ld(input logic [15:0] v, input bit dec, input bit five);
    @(negedge clk);
    value    = v;
    dec_mode = dec;
    if (five) load5 = 1'b1;
    else      load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    load5 = 1'b0;
    exp_q.push_back(model(64'(v), dec, five ? 5 : 4));
  endtask

  task automatic wait_idle(input bit five, output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    while ((five ? busy5 : busy4) && cyc < 200) begin
      for (int k = 0; k < 4; k++)
        if (!five && an4[k] == 1'b0 && seg4 !== shown[k]) bad++;
      cyc++;
      @(negedge clk);
    end
    chk("idle_timeout", five ? busy5 : busy4, 0);
  endtask

  task automatic obs(input bit five, output img_t g, output logic [7:0] d);
    logic [7:0] a;
    int nd;
    nd = five ? 5 : 4;
    g  = {8{7'h55}};
    d  = '1;
    repeat (nd * 32 + 40) begin
      @(negedge clk);
      a = five ? {3'b111, an5} : {4'hF, an4};
      for (int k = 0; k < nd; k++) begin
        if (a[k] == 1'b0) begin
          g[k] = five ? seg5 : seg4;
          d[k] = five ? dp5 : dp4;
        end
      end
    end
  endtask

  task automatic check_image(input string tag, input bit five);
    img_t e, g;
    logic [7:0] d, dexp, mask;
    int nd;
    nd = five ? 5 : 4;
    chk({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    obs(five, g, d);
    for (int k = 0; k < nd; k++)
      chk($sformatf("%s_d%0d", tag, k), g[k], e[k]);
    mask = five ? 8'h1F : 8'h0F;
    dexp = five ? 8'h1F : {4'h0, ~dp_in};
    chk({tag, "_dp"}, d & mask, dexp);
    if (!five) shown = e;
  endtask

  task automatic count_on(input int dig, output int n);
    n = 0;
    repeat (128) begin
      @(negedge clk);
      if (dig < 0 ? (an4 != 4'hF) : (an4[dig] == 1'b0)) n++;
    end
  endtask

  int cyc, bad, n;

  initial begin
    rst = 1'b1; load = 1'b0; load5 = 1'b0; value = '0;
    dec_mode = 1'b0; dp_in = '0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(model(0, 0, 4));
    @(negedge clk);
    chk("rst_an", an4, 4'hF);
    chk("rst_seg", seg4, 7'h7F);
    chk("rst_dp", dp4, 1);
    chk("rst_busy", busy4, 0);
    check_image("rst", 0);

    // decimal conversion with hold of old image
    ld(16'd1234, 1, 0);
    wait_idle(0, cyc, bad);
    chk("dec_busy_len", cyc, 16);
    chk("dec_hold", bad, 0);
    check_image("dec1234", 0);

    // hex, live decimal point
    dp_in = 4'b0010;
    ld(16'hBEEF, 0, 0);
    chk("hex_busy", busy4, 0);
    check_image("hexBEEF", 0);
    ld(16'h0042, 0, 0);
    check_image("hex42", 0);
    dp_in = 4'b0000;

    // overflow and wider panel
    ld(16'd65535, 1, 0);
    wait_idle(0, cyc, bad);
    check_image("ovf4", 0);
    ld(16'd65535, 1, 1);
    wait_idle(1, cyc, bad);
    chk("dec5_busy_len", cyc, 16);
    check_image("dec5", 1);

    // brightness
    brightness = 4'd0;
    count_on(-1, n);
    chk("bright0", n, 0);
    brightness = 4'd8;
    count_on(0, n);
    chk("bright8", n, 15);
    brightness = 4'd15;
    count_on(2, n);
    chk("bright15", n, 29);

    // load while busy is dropped
    ld(16'd1234, 1, 0);
    repeat (2) @(negedge clk);
    value = 16'd9876; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(0, cyc, bad);
    check_image("ignore", 0);
    chk("ignore_idle", busy4, 0);

    // reset in the middle of a conversion
    ld(16'd4321, 1, 0);
    repeat (6) @(negedge clk);
    chk("mid_busy_pre", busy4, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy4, 0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    exp_q.push_back(model(0, 0, 4));
    check_image("rst_mid", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
